// File: rtl/ps2_game_pkg.sv
// Shared scan codes and frame-state encoding for the PS/2 game input path.
package ps2_game_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive deframer: pin synchronisers, falling-edge detect, 11-bit frame FSM,
// odd-parity/stop check and inactivity timeout.
module ps2_rx_frame
  import ps2_game_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  output logic [7:0]   rx_byte,
  output logic         rx_valid,
  output logic         rx_err,
  output frame_state_t state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_cur;
  logic                   dat_cur;
  logic                   fall;

  frame_state_t state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift;
  logic         parity;
  logic [CW-1:0] idle_cnt;
  logic          timed_out;

  assign clk_cur   = clk_sync[SYNC_STAGES-1];
  assign dat_cur   = dat_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~clk_cur;
  assign timed_out = (state != IDLE) && (idle_cnt == CW'(TIMEOUT_CYCLES));
  assign state_dbg = state;

  // Synchronisers reset to the idle-high bus level so reset release never fakes an edge.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_cur;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      idle_cnt <= '0;
    end else if (state == IDLE || fall) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CW'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // rx_valid and rx_err are single-cycle strobes with no back-pressure: the consumer must
  // take rx_byte in the rx_valid cycle; rx_byte holds its value until the next good frame.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      parity   <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (timed_out && !fall) begin
        rx_err <= 1'b1;
        state  <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_cur) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {dat_cur, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity <= dat_cur;
            state  <= STOP;
          end
          STOP: begin
            if (dat_cur && (^{shift, parity})) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_game_input.sv
// PS/2 keyboard front end for vga_controller: deframes bytes and turns make/break
// scan codes into held movement levels, a one-shot fire pulse and a pause toggle.
module ps2_game_input
  import ps2_game_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  frame_state_t frame_state;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .state_dbg(frame_state)
  );

  logic ext, brk, lft_arr, rgt_arr, key_a, key_d, space_held, p_held;
  logic ext_n, brk_n, lft_n, rgt_n, key_a_n, key_d_n, space_n, p_n, fire_n, pause_n;

  always_comb begin
    ext_n   = ext;
    brk_n   = brk;
    lft_n   = lft_arr;
    rgt_n   = rgt_arr;
    key_a_n = key_a;
    key_d_n = key_d;
    space_n = space_held;
    p_n     = p_held;
    pause_n = pause;
    fire_n  = 1'b0;
    if (rx_err) begin
      ext_n = 1'b0;
      brk_n = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_n = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_n = 1'b1;
      end else begin
        ext_n = 1'b0;
        brk_n = 1'b0;
        // Extended and plain code spaces are disjoint; unknown codes only drop the prefixes.
        if (ext) begin
          case (rx_byte)
            SC_LEFT:  lft_n = !brk;
            SC_RIGHT: rgt_n = !brk;
            default:  ;
          endcase
        end else begin
          case (rx_byte)
            SC_A: key_a_n = !brk;
            SC_D: key_d_n = !brk;
            SC_SPACE: begin
              if (brk) begin
                space_n = 1'b0;
              end else if (!space_held) begin
                space_n = 1'b1;
                fire_n  = 1'b1;
              end
            end
            SC_P: begin
              if (brk) begin
                p_n = 1'b0;
              end else if (!p_held) begin
                p_n     = 1'b1;
                pause_n = !pause;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      lft_arr    <= 1'b0;
      rgt_arr    <= 1'b0;
      key_a      <= 1'b0;
      key_d      <= 1'b0;
      space_held <= 1'b0;
      p_held     <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      pause      <= 1'b0;
    end else begin
      ext        <= ext_n;
      brk        <= brk_n;
      lft_arr    <= lft_n;
      rgt_arr    <= rgt_n;
      key_a      <= key_a_n;
      key_d      <= key_d_n;
      space_held <= space_n;
      p_held     <= p_n;
      move_left  <= lft_n | key_a_n;
      move_right <= rgt_n | key_d_n;
      fire       <= fire_n;
      pause      <= pause_n;
    end
  end

endmodule
